// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the prefetch queue: reset vector, code byte type,
// count-width helper and a saturating statistics increment.
package cpu_pkg;

    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_FFFC;

    localparam int CODE_BYTE_W = 8;
    typedef logic [CODE_BYTE_W-1:0] code_byte_t;

    localparam int STAT_W = 16;

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/prefetch_ram.sv
// Circular code-byte storage for the prefetch queue: one write port and
// PEEK_W asynchronous read ports at consecutive addresses starting from head.
module prefetch_ram #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int PEEK_W = 3,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                           i_clk,
    input  logic                           i_we,
    input  logic [PTR_W-1:0]               i_waddr,
    input  logic [DATA_W-1:0]              i_wdata,
    input  logic [PTR_W-1:0]               i_head,
    output logic [PEEK_W-1:0][DATA_W-1:0]  o_rd
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset; stale entries are never visible because the
    // controller masks every read slot at or beyond the valid count.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Index arithmetic is PTR_W bits wide, so it wraps around the ring for free.
    always_comb begin
        for (int k = 0; k < PEEK_W; k++) begin
            o_rd[k] = r_mem[PTR_W'(i_head + PTR_W'(k))];
        end
    end

endmodule

// File: rtl/cpu_prefetch_queue.sv
// Decoupled instruction prefetcher: streams code bytes into a ring ahead of the PC.
// Optional PREFETCH_STATS_EN adds saturating flush and starve counters.
module cpu_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int                 ADDR_W     = 32,
    parameter int                 DATA_W     = 8,
    parameter int                 DEPTH      = 8,
    parameter int                 PEEK_W     = 3,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = ADDR_W'(RESET_ADDR_DEFAULT),
    localparam int                CNT_W      = cnt_width(DEPTH),
    localparam int                CONS_W     = cnt_width(PEEK_W)
) (
    input  logic                      i_cpu_clk,
    input  logic                      i_rst,
    output logic                      o_mem_req,
    output logic [ADDR_W-1:0]         o_mem_addr,
    input  logic [DATA_W-1:0]         i_mem_data,
    input  logic                      i_mem_ready,
    output logic [PEEK_W*DATA_W-1:0]  o_q_data,
    output logic [CNT_W-1:0]          o_q_count,
    output logic [ADDR_W-1:0]         o_q_pc,
    input  logic [CONS_W-1:0]         i_consume,
    output logic                      o_underflow,
    input  logic                      i_flush,
    input  logic [ADDR_W-1:0]         i_flush_addr
`ifdef PREFETCH_STATS_EN
    ,
    output logic [STAT_W-1:0]         o_flush_cnt,
    output logic [STAT_W-1:0]         o_starve_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]                r_head;
    logic [PTR_W-1:0]                r_tail;
    logic [CNT_W-1:0]                r_count;
    logic [ADDR_W-1:0]               r_fa;
    logic [ADDR_W-1:0]               r_mem_addr;
    logic [ADDR_W-1:0]               r_q_pc;
    logic                            r_req;
    logic                            r_discard;
    logic                            r_underflow;

    logic                            w_complete;
    logic                            w_push;
    logic                            w_open_next;
    logic                            w_req_next;
    logic [CNT_W-1:0]                w_cons_req;
    logic [CNT_W-1:0]                w_cons;
    logic [CNT_W-1:0]                w_count_next;
    logic [ADDR_W-1:0]               w_fa_next;
    logic [PEEK_W-1:0][DATA_W-1:0]   w_rd;

    // The open request doubles as the pending flag: o_mem_req stays high until ready.
    always_comb begin
        w_complete  = r_req && i_mem_ready;
        w_push      = w_complete && !r_discard && !i_flush;
        w_cons_req  = CNT_W'(i_consume);
        w_cons      = (w_cons_req > r_count) ? r_count : w_cons_req;
        w_open_next = r_req && !i_mem_ready;

        if (i_flush) begin
            w_count_next = '0;
        end else begin
            w_count_next = r_count + CNT_W'(w_push) - w_cons;
        end

        // A discarded completion must not advance fa: it already holds the flush target.
        if (i_flush) begin
            w_fa_next = i_flush_addr;
        end else if (w_complete && !r_discard) begin
            w_fa_next = r_fa + ADDR_W'(1);
        end else begin
            w_fa_next = r_fa;
        end

        w_req_next = w_open_next || (w_count_next < CNT_W'(DEPTH));
    end

    // NOTE: every state register uses non-blocking assignments so all of them
    // update from the same pre-edge values computed in the block above.
    always_ff @(posedge i_cpu_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_fa        <= RESET_ADDR;
            r_mem_addr  <= RESET_ADDR;
            r_q_pc      <= RESET_ADDR;
            r_req       <= 1'b0;
            r_discard   <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_req   <= w_req_next;
            r_fa    <= w_fa_next;
            r_count <= w_count_next;
            if (!w_open_next) begin
                r_mem_addr <= w_fa_next;
            end
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (i_flush) begin
                r_head      <= r_tail;
                r_q_pc      <= i_flush_addr;
                r_discard   <= w_open_next;
                r_underflow <= 1'b0;
            end else begin
                r_head      <= r_head + PTR_W'(w_cons);
                r_q_pc      <= r_q_pc + ADDR_W'(w_cons);
                r_underflow <= (w_cons_req > r_count);
                if (w_complete) begin
                    r_discard <= 1'b0;
                end
            end
        end
    end

    prefetch_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .PEEK_W (PEEK_W)
    ) u_ram (
        .i_clk   (i_cpu_clk),
        .i_we    (w_push),
        .i_waddr (r_tail),
        .i_wdata (i_mem_data),
        .i_head  (r_head),
        .o_rd    (w_rd)
    );

    always_comb begin
        o_q_data = '0;
        for (int k = 0; k < PEEK_W; k++) begin
            if (CNT_W'(k) < r_count) begin
                o_q_data[k*DATA_W +: DATA_W] = w_rd[k];
            end
        end
    end

    assign o_mem_req   = r_req;
    assign o_mem_addr  = r_mem_addr;
    assign o_q_count   = r_count;
    assign o_q_pc      = r_q_pc;
    assign o_underflow = r_underflow;

`ifdef PREFETCH_STATS_EN
    logic [STAT_W-1:0] r_flush_cnt;
    logic [STAT_W-1:0] r_starve_cnt;

    // A flush cycle is never counted as starvation, even though the queue empties.
    always_ff @(posedge i_cpu_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flush_cnt  <= '0;
            r_starve_cnt <= '0;
        end else if (i_flush) begin
            r_flush_cnt <= sat_inc(r_flush_cnt);
        end else if (r_count < CNT_W'(PEEK_W)) begin
            r_starve_cnt <= sat_inc(r_starve_cnt);
        end
    end

    assign o_flush_cnt  = r_flush_cnt;
    assign o_starve_cnt = r_starve_cnt;
`endif

endmodule

// File: tb/tb_cpu_prefetch_queue.sv
// Self-checking bench for cpu_prefetch_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_cpu_prefetch_queue;
    import cpu_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int PEEK_W = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_data = '0;
    logic               mem_ready = 1'b0;
    logic [23:0]        q_data;
    logic [3:0]         q_count;
    logic [ADDR_W-1:0]  q_pc;
    logic [1:0]         consume = '0;
    logic               underflow;
    logic               flush = 1'b0;
    logic [ADDR_W-1:0]  flush_addr = '0;
`ifdef PREFETCH_STATS_EN
    logic [15:0]        flush_cnt;
    logic [15:0]        starve_cnt;
`endif

    always #5 clk = ~clk;

    cpu_prefetch_queue dut (
        .i_cpu_clk    (clk),
        .i_rst        (rst),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_data   (mem_data),
        .i_mem_ready  (mem_ready),
        .o_q_data     (q_data),
        .o_q_count    (q_count),
        .o_q_pc       (q_pc),
        .i_consume    (consume),
        .o_underflow  (underflow),
        .i_flush      (flush),
        .i_flush_addr (flush_addr)
`ifdef PREFETCH_STATS_EN
        ,
        .o_flush_cnt  (flush_cnt),
        .o_starve_cnt (starve_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the queue contents as a plain list plus fetch bookkeeping.
    code_byte_t   m_q[$];
    logic [31:0]  m_pc, m_fa, m_addr;
    bit           m_req, m_disc, m_uf;
    logic [15:0]  m_fcnt, m_scnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc   = 32'h0000_FFFC;
        m_fa   = 32'h0000_FFFC;
        m_addr = 32'h0000_FFFC;
        m_req  = 0;
        m_disc = 0;
        m_uf   = 0;
        m_fcnt = '0;
        m_scnt = '0;
    endtask

    task automatic model_edge(input bit fl, input logic [31:0] faddr, input int cons, input bit rdy);
        int n          = m_q.size();
        bit done       = m_req && rdy;
        bit open_after = m_req && !rdy;
        int c          = (cons > n) ? n : cons;
        if (fl) begin
            if (m_fcnt != 16'hFFFF) m_fcnt++;
        end else if (n < PEEK_W) begin
            if (m_scnt != 16'hFFFF) m_scnt++;
        end
        m_uf = 0;
        if (fl) begin
            m_q.delete();
            m_pc   = faddr;
            m_fa   = faddr;
            m_disc = open_after;
        end else begin
            m_uf = (cons > n);
            repeat (c) void'(m_q.pop_front());
            m_pc += c;
            if (done) begin
                if (!m_disc) begin
                    m_q.push_back(m_addr[7:0]);
                    m_fa += 1;
                end
                m_disc = 0;
            end
        end
        if (!open_after) begin
            m_req  = (m_q.size() < DEPTH);
            m_addr = m_fa;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [23:0] exp_data = '0;
        for (int k = 0; k < PEEK_W; k++) begin
            if (k < m_q.size()) exp_data[k*8 +: 8] = m_q[k];
        end
        check({tag, ".req"},   64'(mem_req),   64'(m_req));
        check({tag, ".addr"},  64'(mem_addr),  64'(m_addr));
        check({tag, ".count"}, 64'(q_count),   64'(m_q.size()));
        check({tag, ".pc"},    64'(q_pc),      64'(m_pc));
        check({tag, ".data"},  64'(q_data),    64'(exp_data));
        check({tag, ".uf"},    64'(underflow), 64'(m_uf));
`ifdef PREFETCH_STATS_EN
        check({tag, ".fcnt"},  64'(flush_cnt),  64'(m_fcnt));
        check({tag, ".scnt"},  64'(starve_cnt), 64'(m_scnt));
`endif
    endtask

    // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
    task automatic step(input string tag, input bit fl, input logic [31:0] faddr,
                        input int cons, input bit rdy);
        flush      = fl;
        flush_addr = faddr;
        consume    = cons[1:0];
        mem_ready  = rdy;
        mem_data   = m_addr[7:0];
        model_edge(fl, faddr, cons, rdy);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        rst = 1'b0;

        // Zero-wait fill from the reset vector.
        for (int i = 0; i < 9; i++) step("fill", 0, '0, 0, 1);
        check("fill.count8", 64'(q_count), 64'd8);
        check("fill.bytes",  64'(q_data),  64'h00FE_FDFC);
        step("full_idle", 0, '0, 0, 1);

        // Consume three on the same edge as a completion.
        step("cons3a", 0, '0, 3, 1);
        step("cons3b", 0, '0, 3, 1);
        check("cons3.count", 64'(q_count), 64'd3);
        check("cons3.pc",    64'(q_pc),    64'h0001_0002);

        // Underflow from a single queued byte.
        step("uf_prep", 0, '0, 2, 0);
        step("uf_hit",  0, '0, 3, 0);
        check("uf.count", 64'(q_count),   64'd0);
        check("uf.pulse", 64'(underflow), 64'd1);
        step("uf_drop", 0, '0, 0, 0);
        check("uf.clear", 64'(underflow), 64'd0);

        // Wait-state memory: ready every third cycle.
        for (int i = 0; i < 30; i++) begin
            step("wait", 0, '0, $urandom_range(0, 3), (i % 3) == 2);
        end

        // Flush while a request to 0x0200 is stalled.
        step("fl_to200", 1, 32'h0000_0200, 0, 1);
        check("fl.addr200", 64'(mem_addr), 64'h200);
        step("fl_stall", 0, '0, 0, 0);
        step("fl_stall", 0, '0, 0, 0);
        step("fl_1234", 1, 32'h0000_1234, 0, 0);
        for (int i = 0; i < 3; i++) step("fl_wait", 0, '0, 0, 0);
        step("fl_stale", 0, '0, 0, 1);
        check("fl.dropped",  64'(q_count),  64'd0);
        check("fl.nextaddr", 64'(mem_addr), 64'h1234);
        check("fl.pc",       64'(q_pc),     64'h1234);
        step("fl_first", 0, '0, 0, 1);
        check("fl.byte", 64'(q_data), 64'h34);

        // Random traffic with occasional flushes, some near the address wrap.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] fa;
            fa = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
            step("rand", $urandom_range(0, 15) == 0, fa,
                 $urandom_range(0, 3), $urandom_range(0, 2) != 0);
        end

        // Asynchronous reset between edges with a request open.
        step("ar_open", 1, 32'h0000_4000, 0, 0);
        check("ar.req_before", 64'(mem_req), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        #1;
        compare_all("rst_hold");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step("post_rst", 0, '0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_prefetch_queue.md
# cpu_prefetch_queue

Parametrised instruction prefetch queue for the 65832 CPU core. It replaces the single-byte, edge-triggered opcode read with a decoupled fetcher. The fetcher streams code bytes from a memory port into a circular buffer ahead of the program counter. The decode stage can see, and consume in one clock, up to three bytes: opcode plus two operand bytes. It sits between the CPU's cycle sequencer and the memory/bus port, and it is flushed on every jump, branch, interrupt vector load or reset.

## Interface
Parameters:
- ADDR_W, 32, fetch address width.
- DATA_W, 8, bits per queued code byte.
- DEPTH, 8, queue entries; power of two, at least 4.
- PEEK_W, 3, bytes presented and consumable per cycle; must be at most DEPTH.
- RESET_ADDR, 32'h0000_FFFC, fetch address loaded at reset.

Ports:
- i_cpu_clk, in, 1, the single clock; all state changes on its rising edge.
- i_rst, in, 1, asynchronous, active-high reset.
- o_mem_req, out, 1, fetch request.
- o_mem_addr, out, ADDR_W, fetch address; valid while o_mem_req is high.
- i_mem_data, in, DATA_W, fetched byte; valid when i_mem_ready is high.
- i_mem_ready, in, 1, completes the current request.
- o_q_data, out, PEEK_W*DATA_W, the oldest PEEK_W bytes; byte 0 is in the LSBs. Bytes at index ≥ o_q_count read 0.
- o_q_count, out, clog2(DEPTH+1), number of valid entries.
- o_q_pc, out, ADDR_W, address of byte 0.
- i_consume, in, clog2(PEEK_W+1), number of bytes retired this cycle.
- o_underflow, out, 1, one-cycle pulse when i_consume exceeds o_q_count.
- i_flush, in, 1, discard the queue and redirect fetch.
- i_flush_addr, in, ADDR_W, new fetch address and new o_q_pc.

## Operation
- The fetch address register (fa) tracks the address of the next byte to request. A pending flag marks an open request, and a discard flag marks a request that was opened before a flush.
- **Request rule:** o_mem_req is asserted when o_q_count + pending < DEPTH.
- Once o_mem_req is asserted, it and o_mem_addr hold stable until an edge samples i_mem_ready high. At most one request is open at a time.
- **Completion:** on an edge with o_mem_req and i_mem_ready both high:
  - i_mem_data is written at the tail, unless discard is set.
  - fa increments by 1, wrapping modulo 2^ADDR_W.
  - The next request may be issued with no idle cycle (back-to-back).
- **Consume:** o_q_pc advances by i_consume and the head pointer advances by i_consume.
  - If i_consume > o_q_count, the consume is clamped to o_q_count and o_underflow pulses.
- Push and consume on the same edge are both applied, so count changes by push − consume.
- **Flush** has priority over push and consume on that edge:
  - count = 0.
  - head = tail.
  - o_q_pc = fa = i_flush_addr.
  - If a request is open, it completes normally but its data is dropped: the discard flag is set and then cleared on completion.
  - No new request is issued until the open one closes.
- Pointers are log2(DEPTH) bits and wrap naturally. Count distinguishes full from empty.
- **Reset** (asynchronous, any time, including mid-request):
  - count = 0, pointers = 0, pending = 0, discard = 0.
  - o_mem_req = 0, o_mem_addr = RESET_ADDR, o_q_pc = RESET_ADDR.
  - o_q_data = 0, o_underflow = 0.
  - Statistics outputs = 0.
  - Any open request is abandoned; the memory side must tolerate this.

## Timing
- All outputs are registered, except o_q_data, which is a mux of the registered array and head pointer.
- On the first edge after i_rst deasserts, o_mem_req goes high with o_mem_addr = RESET_ADDR.
- **Fill latency:** the byte is visible in o_q_data and o_q_count immediately after the edge that samples i_mem_ready.
- With zero-wait memory (i_mem_ready tied high), the queue fills one byte per clock and is full DEPTH edges after the first request.
- **Flush to first valid byte:** 2 edges with an idle bus and zero-wait memory (request edge, then ready edge). Add the remaining wait on the open request if one was pending.
- **Full boundary:**
  - With count = DEPTH − 1 and a request open, no further request is issued.
  - Consuming in the same edge as the completion re-enables requests on the next edge.

## Configuration
- PREFETCH_STATS_EN defined: adds two 16-bit saturating outputs.
  - o_flush_cnt: number of flushes.
  - o_starve_cnt: cycles with o_q_count < PEEK_W and no flush.
  - Both clear only on reset.
- PREFETCH_STATS_EN undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package cpu_pkg additions:
  - The RESET_ADDR default.
  - The byte typedef (DATA_W = 8).
  - A clog2-based count-width constant function.
- One natural sub-module, prefetch_ram: the DEPTH × DATA_W circular storage, with one write port and PEEK_W asynchronous read ports indexed from head. The controller holds the pointers, fa, pending/discard and flush logic.

## Test plan
- **Reset fill:** RESET_ADDR = 0xFFFC, i_mem_ready = 1, i_mem_data = low byte of address, DEPTH = 8, i_consume = 0.
  - o_mem_addr must run 0xFFFC … 0x10003.
  - o_q_count must reach 8 after 9 edges.
  - o_q_data must read 0x FE FD FC.
- **Wait states:** i_mem_ready is high every third cycle.
  - o_mem_addr must stay stable between ready pulses.
  - Exactly one byte is pushed per ready pulse.
- **Consume 3 while pushing 1:** queue at count 5, i_consume = 3 with a completion on the same edge.
  - count must be 3.
  - o_q_pc must advance by 3.
- **Flush with an open request:** request to 0x0200 stalled, then i_flush with i_flush_addr = 0x1234, then ready after 4 cycles.
  - The stale byte must be dropped.
  - The next request must be to 0x1234.
  - o_q_pc must be 0x1234.
- **Underflow:** count = 1, i_consume = 3.
  - count must be 0.
  - o_underflow must be high for exactly one cycle.
- **Asynchronous reset mid-request:** assert i_rst between edges.
  - o_mem_req must drop immediately.
  - All outputs must be at their reset values before the next edge.
  - Under PREFETCH_STATS_EN, the counters must read 0.
